exc_collect: RTL and testbench
==============================

// Module: exc_collect
// PURPOSE
//  MEM-stage exception collector feeding CP0. Merges per-instruction exception flags, ERET and
//  masked hardware/timer interrupts into one prioritised exception record. Tracks branch delay
//  slots. Registers exc_code/epc/badvaddr/in_delay for CP0 to consume on the next edge.
//  A hold FSM masks duplicate exceptions while the pipeline flushes and redirects.
// PARAMETERS
//  FLUSH_CYCLES  3  cycles in HOLD after any issued exception/ERET (legal range >=1)
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset; asynchronous, active-low
//  mem_valid_i      in   1   valid instruction in MEM this cycle
//  mem_pc_i         in   32  PC of MEM instruction
//  mem_is_branch_i  in   1   MEM instruction is branch/jump (next one is a delay slot)
//  mem_addr_i       in   32  data address of MEM load/store
//  mem_adel_if_i    in   1   fetch address error
//  mem_ri_i         in   1   reserved instruction
//  mem_ov_i         in   1   arithmetic overflow
//  mem_sys_i        in   1   syscall
//  mem_bp_i         in   1   break
//  mem_adel_i       in   1   load address error
//  mem_ades_i       in   1   store address error
//  mem_eret_i       in   1   ERET
//  int_i            in   6   external hardware interrupts (async, level)
//  int_time_i       in   1   CP0 timer interrupt
//  status_i         in   32  CP0 Status (IE=bit0, EXL=bit1, IM[7:2]=bits15:10)
//  exc_code_o       out  5   to CP0 exc_code_i; EC_None when idle
//  exc_epc_o        out  32  to CP0 exc_epc_i
//  exc_badvaddr_o   out  32  to CP0 exc_badvaddr_i
//  in_delay_o       out  1   to CP0 in_delay_i
//  flush_pending_o  out  1   1 while in HOLD; upstream squashes/stalls
// BEHAVIOUR
//  - Reset (rst=0, async): exc_code_o=EC_None; exc_epc_o, exc_badvaddr_o = 0; in_delay_o=0;
//    flush_pending_o=0; FSM=IDLE; hold counter=0; last_branch=0; sync flops=0.
//  - ip[7:2] = {int_s[5] | int_time_i, int_s[4:0]}, where int_s is synchronised int_i.
//    take_int = |(ip & status_i[15:10]) & status_i[0] & ~status_i[1].
//  - Priority, IDLE and mem_valid_i only:
//    Int(0) > AdEL-fetch(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdEL(4) > AdES(5) > ERET(EC_Eret).
//    Nothing set gives EC_None.
//  - in_delay = mem_valid_i & last_branch.
//    exc_epc = in_delay ? mem_pc_i-4 : mem_pc_i, mod 2^32 (pc 0 in slot gives 0xFFFFFFFC).
//    ERET: epc=0.
//  - badvaddr: fetch AdEL -> mem_pc_i; data AdEL/AdES -> mem_addr_i; all other codes -> 0.
//  - Outputs are registered, with 1-cycle latency. The MEM instruction at edge N appears on the
//    outputs after edge N. Outputs hold for exactly one cycle, then return to EC_None/0.
//  - FSM IDLE: if a non-None code is selected, issue it, load cnt=FLUSH_CYCLES-1 and go to HOLD.
//    Otherwise, if mem_valid_i, last_branch<=mem_is_branch_i.
//  - FSM HOLD: flush_pending_o=1; exc_code_o=EC_None; all MEM inputs are ignored.
//    cnt==0 goes to IDLE, else cnt--. last_branch is cleared on issue.
//  - Interrupts raised during HOLD are not lost while still asserted (level).
//    They are taken on the first valid instruction after IDLE.
//  - Same cycle interrupt + sync exception: the interrupt wins and the instruction is replayed by
//    the handler. mem_valid_i=0 never issues anything, including interrupts.
//  - Reset mid-HOLD: immediate return to IDLE with reset values; no partial record.
// CONFIGURATION
//  INT_SYNC_EN defined: int_i passes through a 2-flop synchroniser. int_i to ip latency is
//  2 edges, so the earliest exc_code_o=0 is after the 3rd edge.
//  INT_SYNC_EN undefined: single register stage. Latency is 1 edge, so exc_code_o=0 after the
//  2nd edge. int_time_i is never synchronised.
// TESTING
//  1. RI, pc=0xBFC00100, no prior branch -> next cycle code=10, epc=0xBFC00100, in_delay=0;
//     flush_pending_o=1 for 3 cycles.
//  2. Branch at 0x80000000 accepted, then syscall at 0x80000004 -> code=8, epc=0x80000000,
//     in_delay=1.
//  3. Status=0x00001001, int_i=6'b000100, mem_valid_i held 1 -> code=0 after edge 3 (sync on);
//     with status=0x00001003 (EXL) no exception.
//  4. mem_ades_i + mem_ov_i, addr=0x00000003 -> code=12, badvaddr=0; ades alone -> code=5,
//     badvaddr=0x00000003.
//  5. ERET -> code=EC_Eret, epc=0. RI presented during the following HOLD -> no issue, code
//     stays EC_None.
//  6. rst=0 asserted mid-HOLD, between edges -> all outputs at reset values immediately,
//     flush_pending_o=0.

Source files
------------

// File: rtl/exc_collect_if.sv
// rtl/exc_collect_if.sv - MEM-stage exception bus between pipeline, interrupt sources and CP0
interface exc_collect_if;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_is_branch_i;
  logic [31:0] mem_addr_i;
  logic        mem_adel_if_i;
  logic        mem_ri_i;
  logic        mem_ov_i;
  logic        mem_sys_i;
  logic        mem_bp_i;
  logic        mem_adel_i;
  logic        mem_ades_i;
  logic        mem_eret_i;
  logic [5:0]  int_i;
  logic        int_time_i;
  logic [31:0] status_i;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_epc_o;
  logic [31:0] exc_badvaddr_o;
  logic        in_delay_o;
  logic        flush_pending_o;

  modport master (
    output mem_valid_i, mem_pc_i, mem_is_branch_i, mem_addr_i,
           mem_adel_if_i, mem_ri_i, mem_ov_i, mem_sys_i, mem_bp_i,
           mem_adel_i, mem_ades_i, mem_eret_i, int_i, int_time_i, status_i,
    input  exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o, flush_pending_o
  );

  modport slave (
    input  mem_valid_i, mem_pc_i, mem_is_branch_i, mem_addr_i,
           mem_adel_if_i, mem_ri_i, mem_ov_i, mem_sys_i, mem_bp_i,
           mem_adel_i, mem_ades_i, mem_eret_i, int_i, int_time_i, status_i,
    output exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o, flush_pending_o
  );
endinterface

// File: rtl/exc_collect.sv
// rtl/exc_collect.sv - MEM-stage prioritised exception collector for CP0 (option macro: INT_SYNC_EN)
module exc_collect #(
  parameter int FLUSH_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  exc_collect_if.slave bus
);

  localparam logic [4:0] EC_INT  = 5'd0;
  localparam logic [4:0] EC_ADEL = 5'd4;
  localparam logic [4:0] EC_ADES = 5'd5;
  localparam logic [4:0] EC_SYS  = 5'd8;
  localparam logic [4:0] EC_BP   = 5'd9;
  localparam logic [4:0] EC_RI   = 5'd10;
  localparam logic [4:0] EC_OV   = 5'd12;
  localparam logic [4:0] EC_ERET = 5'h0e;
  localparam logic [4:0] EC_NONE = 5'h1f;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        last_branch_q, last_branch_d;
  logic [4:0]  code_d;
  logic [31:0] epc_d;
  logic [31:0] badv_d;
  logic        delay_d;

  logic [5:0]  int_s;
  logic [5:0]  ip;
  logic        take_int;
  logic        in_delay;
  logic [31:0] slot_epc;
  logic [4:0]  sel_code;
  logic [31:0] sel_epc;
  logic [31:0] sel_badv;
  logic        unused_status;

`ifdef INT_SYNC_EN
  logic [5:0] int_meta;

  // Two-flop synchroniser for the asynchronous hardware interrupt lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_meta <= '0;
      int_s    <= '0;
    end else begin
      int_meta <= bus.int_i;
      int_s    <= int_meta;
    end
  end
`else
  // Single register stage on the hardware interrupt lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) int_s <= '0;
    else      int_s <= bus.int_i;
  end
`endif

  assign ip       = {int_s[5] | bus.int_time_i, int_s[4:0]};
  assign take_int = (|(ip & bus.status_i[15:10])) & bus.status_i[0] & ~bus.status_i[1];
  assign in_delay = bus.mem_valid_i & last_branch_q;
  assign slot_epc = in_delay ? bus.mem_pc_i - 32'd4 : bus.mem_pc_i;
  assign unused_status = ^{bus.status_i[31:16], bus.status_i[9:2]};

  // Priority encode the MEM instruction's exception; interrupts only ride on a valid instruction
  always_comb begin
    sel_code = EC_NONE;
    sel_epc  = slot_epc;
    sel_badv = '0;
    if (bus.mem_valid_i) begin
      if (take_int)                sel_code = EC_INT;
      else if (bus.mem_adel_if_i) begin
        sel_code = EC_ADEL;
        sel_badv = bus.mem_pc_i;
      end
      else if (bus.mem_ri_i)       sel_code = EC_RI;
      else if (bus.mem_ov_i)       sel_code = EC_OV;
      else if (bus.mem_sys_i)      sel_code = EC_SYS;
      else if (bus.mem_bp_i)       sel_code = EC_BP;
      else if (bus.mem_adel_i) begin
        sel_code = EC_ADEL;
        sel_badv = bus.mem_addr_i;
      end
      else if (bus.mem_ades_i) begin
        sel_code = EC_ADES;
        sel_badv = bus.mem_addr_i;
      end
      else if (bus.mem_eret_i) begin
        sel_code = EC_ERET;
        sel_epc  = '0;
      end
    end
  end

  // Hold FSM next state and one-cycle exception record
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_branch_d = last_branch_q;
    code_d        = EC_NONE;
    epc_d         = '0;
    badv_d        = '0;
    delay_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_code != EC_NONE) begin
          code_d        = sel_code;
          epc_d         = sel_epc;
          badv_d        = sel_badv;
          delay_d       = in_delay;
          state_d       = HOLD;
          cnt_d         = CNT_LOAD;
          last_branch_d = 1'b0;
        end else if (bus.mem_valid_i) begin
          last_branch_d = bus.mem_is_branch_i;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, delay-slot tracker and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      last_branch_q      <= 1'b0;
      bus.exc_code_o     <= EC_NONE;
      bus.exc_epc_o      <= '0;
      bus.exc_badvaddr_o <= '0;
      bus.in_delay_o     <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      last_branch_q      <= last_branch_d;
      bus.exc_code_o     <= code_d;
      bus.exc_epc_o      <= epc_d;
      bus.exc_badvaddr_o <= badv_d;
      bus.in_delay_o     <= delay_d;
    end
  end

  assign bus.flush_pending_o = (state_q == HOLD);

endmodule

// File: tb/tb_exc_collect.sv
// tb/tb_exc_collect.sv - directed self-checking bench for exc_collect
module tb_exc_collect;

  localparam logic [31:0] EC_NONE = 32'h1f;
  localparam logic [31:0] EC_ERET = 32'h0e;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  exc_collect_if bus ();

  exc_collect #(.FLUSH_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    bus.mem_valid_i     = 1'b0;
    bus.mem_pc_i        = '0;
    bus.mem_is_branch_i = 1'b0;
    bus.mem_addr_i      = '0;
    bus.mem_adel_if_i   = 1'b0;
    bus.mem_ri_i        = 1'b0;
    bus.mem_ov_i        = 1'b0;
    bus.mem_sys_i       = 1'b0;
    bus.mem_bp_i        = 1'b0;
    bus.mem_adel_i      = 1'b0;
    bus.mem_ades_i      = 1'b0;
    bus.mem_eret_i      = 1'b0;
  endtask

  // Clear MEM inputs and wait out the three HOLD cycles after an issue
  task automatic drain();
    clear_mem();
    repeat (3) tick();
  endtask

  task automatic present(input logic [31:0] pc);
    clear_mem();
    bus.mem_valid_i = 1'b1;
    bus.mem_pc_i    = pc;
  endtask

  task automatic check_idle_outputs(input string tag);
    expect_eq({tag, "_code"},  32'(bus.exc_code_o), EC_NONE);
    expect_eq({tag, "_epc"},   bus.exc_epc_o, 32'h0);
    expect_eq({tag, "_badv"},  bus.exc_badvaddr_o, 32'h0);
    expect_eq({tag, "_delay"}, 32'(bus.in_delay_o), 32'h0);
    expect_eq({tag, "_flush"}, 32'(bus.flush_pending_o), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    clear_mem();
    bus.int_i      = '0;
    bus.int_time_i = 1'b0;
    bus.status_i   = '0;

    // Reset state
    #12;
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // 1: RI with no prior branch, then three HOLD cycles
    present(32'hBFC00100);
    bus.mem_ri_i = 1'b1;
    tick();
    expect_eq("t1_code",   32'(bus.exc_code_o), 32'd10);
    expect_eq("t1_epc",    bus.exc_epc_o, 32'hBFC00100);
    expect_eq("t1_delay",  32'(bus.in_delay_o), 32'h0);
    expect_eq("t1_flush0", 32'(bus.flush_pending_o), 32'h1);
    clear_mem();
    tick();
    expect_eq("t1_flush1", 32'(bus.flush_pending_o), 32'h1);
    expect_eq("t1_code1",  32'(bus.exc_code_o), EC_NONE);
    tick();
    expect_eq("t1_flush2", 32'(bus.flush_pending_o), 32'h1);
    tick();
    expect_eq("t1_flush3", 32'(bus.flush_pending_o), 32'h0);

    // 2: syscall in a branch delay slot
    present(32'h80000000);
    bus.mem_is_branch_i = 1'b1;
    tick();
    expect_eq("t2_br_code", 32'(bus.exc_code_o), EC_NONE);
    present(32'h80000004);
    bus.mem_sys_i = 1'b1;
    tick();
    expect_eq("t2_code",  32'(bus.exc_code_o), 32'd8);
    expect_eq("t2_epc",   bus.exc_epc_o, 32'h80000000);
    expect_eq("t2_delay", 32'(bus.in_delay_o), 32'h1);
    drain();

    // 2b: break in delay slot at pc 0 wraps epc
    present(32'hFFFFFFFC);
    bus.mem_is_branch_i = 1'b1;
    tick();
    present(32'h00000000);
    bus.mem_bp_i = 1'b1;
    tick();
    expect_eq("t2b_code", 32'(bus.exc_code_o), 32'd9);
    expect_eq("t2b_epc",  bus.exc_epc_o, 32'hFFFFFFFC);
    drain();

    // 3: interrupt latency through the synchroniser
    bus.status_i = 32'h00001001;
    present(32'h80001000);
    bus.int_i = 6'b000100;
    tick();
    expect_eq("t3_e1", 32'(bus.exc_code_o), EC_NONE);
`ifdef INT_SYNC_EN
    tick();
    expect_eq("t3_e2", 32'(bus.exc_code_o), EC_NONE);
`endif
    tick();
    expect_eq("t3_code", 32'(bus.exc_code_o), 32'd0);
    expect_eq("t3_epc",  bus.exc_epc_o, 32'h80001000);
    drain();

    // 3b: pending interrupt without a valid instruction issues nothing
    clear_mem();
    repeat (3) begin
      tick();
      expect_eq("t3b_noval", 32'(bus.exc_code_o), EC_NONE);
    end

    // 3c: interrupt beats a same-cycle RI
    present(32'h80001100);
    bus.mem_ri_i = 1'b1;
    tick();
    expect_eq("t3c_code", 32'(bus.exc_code_o), 32'd0);
    drain();

    // 3d: EXL masks the interrupt
    bus.status_i = 32'h00001003;
    present(32'h80001200);
    repeat (4) begin
      tick();
      expect_eq("t3d_exl", 32'(bus.exc_code_o), EC_NONE);
    end
    bus.int_i    = '0;
    bus.status_i = '0;
    clear_mem();
    repeat (3) tick();

    // 4: Ov outranks AdES; AdES alone reports the data address
    present(32'h80002000);
    bus.mem_addr_i = 32'h00000003;
    bus.mem_ades_i = 1'b1;
    bus.mem_ov_i   = 1'b1;
    tick();
    expect_eq("t4_ov_code", 32'(bus.exc_code_o), 32'd12);
    expect_eq("t4_ov_badv", bus.exc_badvaddr_o, 32'h0);
    drain();
    present(32'h80002004);
    bus.mem_addr_i = 32'h00000003;
    bus.mem_ades_i = 1'b1;
    tick();
    expect_eq("t4_ades_code", 32'(bus.exc_code_o), 32'd5);
    expect_eq("t4_ades_badv", bus.exc_badvaddr_o, 32'h00000003);
    drain();

    // 4b: fetch AdEL outranks data AdEL and reports the pc
    present(32'h80002001);
    bus.mem_addr_i    = 32'h00000011;
    bus.mem_adel_if_i = 1'b1;
    bus.mem_adel_i    = 1'b1;
    tick();
    expect_eq("t4b_code", 32'(bus.exc_code_o), 32'd4);
    expect_eq("t4b_badv", bus.exc_badvaddr_o, 32'h80002001);
    drain();

    // 5: ERET, then RI ignored while holding
    present(32'h80003000);
    bus.mem_eret_i = 1'b1;
    tick();
    expect_eq("t5_code", 32'(bus.exc_code_o), EC_ERET);
    expect_eq("t5_epc",  bus.exc_epc_o, 32'h0);
    present(32'h80003004);
    bus.mem_ri_i = 1'b1;
    repeat (3) begin
      tick();
      expect_eq("t5_hold_code", 32'(bus.exc_code_o), EC_NONE);
    end
    clear_mem();
    tick();
    expect_eq("t5_after", 32'(bus.exc_code_o), EC_NONE);

    // 6: asynchronous reset in the middle of HOLD
    present(32'h80004000);
    bus.mem_ri_i = 1'b1;
    tick();
    expect_eq("t6_issue", 32'(bus.exc_code_o), 32'd10);
    clear_mem();
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    #3;
    rst = 1'b1;
    tick();
    present(32'h80004100);
    bus.mem_ri_i = 1'b1;
    tick();
    expect_eq("t6_reissue", 32'(bus.exc_code_o), 32'd10);
    expect_eq("t6_epc",     bus.exc_epc_o, 32'h80004100);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
